// File: rtl/coax_pkg.sv
// rtl/coax_pkg.sv - shared FSM states and error codes for the coax receive path
package coax_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_RECEIVING = 2'd1,
    STATE_ERROR     = 2'd2
  } state_t;

  localparam int WORD_W = 10;

  localparam logic [WORD_W-1:0] ERROR_LOSS_OF_MID_BIT_TRANSITION = 10'b0000000001;
  localparam logic [WORD_W-1:0] ERROR_PARITY                     = 10'b0000000010;
  localparam logic [WORD_W-1:0] ERROR_INVALID_END_SEQUENCE       = 10'b0000000100;
  localparam logic [WORD_W-1:0] ERROR_OVERFLOW                   = 10'b0000001000;

endpackage

// File: rtl/coax_fifo.sv
// rtl/coax_fifo.sv - first-word-fall-through word store with wrap-bit pointers
// Optional occupancy output under COAX_RX_BUFFER_WORD_COUNT_EN.
module coax_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a full buffer may still accept a write.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
  assign count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: rtl/coax_rx_buffer.sv
// rtl/coax_rx_buffer.sv - frame FSM and sticky error capture around the coax word buffer
// Optional count output under COAX_RX_BUFFER_WORD_COUNT_EN.
module coax_rx_buffer
  import coax_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_active,
  input  logic [9:0]             rx_data,
  input  logic                   rx_strobe,
  input  logic                   rx_error,
  output logic [9:0]             data,
  output logic                   empty,
  output logic                   full,
  input  logic                   read_strobe,
  output logic                   error,
  output logic [9:0]             error_code,
  output logic                   frame_done
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  state_t      state_q, state_d;
  logic        active_q;
  logic [9:0]  code_q, code_d;
  logic        done_q, done_d;
  logic        in_error;
  logic        rd_take;
  logic        overflow;
  logic        wr_req;

  assign in_error = (state_q == STATE_ERROR);
  assign rd_take  = read_strobe && !empty;
  assign overflow = rx_strobe && full && !rd_take;
  assign wr_req   = rx_strobe && !rx_error && !in_error;

  coax_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_req),
    .wr_data (rx_data),
    .rd_en   (read_strobe),
    .rd_data (data),
    .empty   (empty),
    .full    (full)
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
    ,
    .count   (count)
`endif
  );

  // rx_error outranks a coincident overflow so the receiver's own code is kept.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    done_d  = 1'b0;
    if (!in_error && rx_error) begin
      state_d = STATE_ERROR;
      code_d  = rx_data;
    end else if (!in_error && overflow) begin
      state_d = STATE_ERROR;
      code_d  = ERROR_OVERFLOW;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (rx_active && !active_q) state_d = STATE_IDLE == STATE_IDLE ? STATE_RECEIVING : STATE_IDLE;
        end
        STATE_RECEIVING: begin
          if (!rx_active && active_q) begin
            state_d = STATE_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // active_q resets high so a frame still in flight across reset is never resumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      active_q <= 1'b1;
      code_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= rx_active;
      code_q   <= code_d;
      done_q   <= done_d;
    end
  end

  assign error      = in_error;
  assign error_code = code_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb/tb_coax_rx_buffer.sv - directed and random checks of coax_rx_buffer against a queue model
module tb_coax_rx_buffer;
  import coax_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_active;
  logic [9:0] rx_data;
  logic       rx_strobe;
  logic       rx_error;
  logic [9:0] data;
  logic       empty;
  logic       full;
  logic       read_strobe;
  logic       error;
  logic [9:0] error_code;
  logic       frame_done;
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
  logic [CW-1:0] count;
`endif

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_active   (rx_active),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .rx_error    (rx_error),
    .data        (data),
    .empty       (empty),
    .full        (full),
    .read_strobe (read_strobe),
    .error       (error),
    .error_code  (error_code),
    .frame_done  (frame_done)
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
    ,
    .count       (count)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] mq[$];
  logic       m_err;
  logic [9:0] m_code;
  logic       m_recv;
  logic       m_prev;
  logic       m_fd;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic compare_all();
    check("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    check("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    check("error", {31'b0, error}, {31'b0, m_err});
    check("error_code", {22'b0, error_code}, {22'b0, m_code});
    check("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    if (mq.size() > 0) check("data", {22'b0, data}, {22'b0, mq[0]});
`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
    check("count", 32'(count), 32'(mq.size()));
`endif
  endtask

  task automatic tick();
    logic rd, wr, fd;
    logic [9:0] wdata;
    rd = read_strobe && (mq.size() > 0);
    wr = 1'b0;
    fd = 1'b0;
    wdata = rx_data;
    if (!m_err) begin
      if (rx_error) begin
        m_err = 1'b1;
        m_code = rx_data;
      end else if (rx_strobe) begin
        if (mq.size() == DEPTH && !rd) begin
          m_err = 1'b1;
          m_code = ERROR_OVERFLOW;
        end else begin
          wr = 1'b1;
        end
      end
    end
    if (!m_err) begin
      if (!m_recv && !m_prev && rx_active) m_recv = 1'b1;
      else if (m_recv && m_prev && !rx_active) begin
        m_recv = 1'b0;
        fd = 1'b1;
      end
    end
    m_prev = rx_active;
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(wdata);
    @(posedge clk);
    #1;
    m_fd = fd;
    compare_all();
  endtask

  task automatic idle_inputs();
    rx_strobe = 1'b0;
    rx_error = 1'b0;
    read_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    mq.delete();
    m_err = 1'b0;
    m_code = '0;
    m_recv = 1'b0;
    m_prev = 1'b1;
    m_fd = 1'b0;
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic put(input logic [9:0] w);
    rx_strobe = 1'b1;
    rx_data = w;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic start_frame();
    rx_active = 1'b0;
    tick();
    rx_active = 1'b1;
    tick();
  endtask

  logic [9:0] words[10];

  initial begin
    reset = 1'b0;
    rx_active = 1'b0;
    rx_data = '0;
    idle_inputs();
    #1;
    do_reset();

    // single word frame
    start_frame();
    put(10'b0110110011);
    rx_active = 1'b0;
    tick();
    check("sw_frame_done", {31'b0, frame_done}, 32'd1);
    check("sw_data", {22'b0, data}, {22'b0, 10'b0110110011});
    check("sw_empty", {31'b0, empty}, 32'd0);
    tick();
    check("sw_done_once", {31'b0, frame_done}, 32'd0);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    check("sw_empty_after_read", {31'b0, empty}, 32'd1);

    // fill then overflow
    do_reset();
    start_frame();
    for (int i = 0; i < 4; i++) begin
      words[i] = 10'($urandom);
      put(words[i]);
    end
    check("fill_full", {31'b0, full}, 32'd1);
    put(10'h3ff);
    check("ovf_error", {31'b0, error}, 32'd1);
    check("ovf_code", {22'b0, error_code}, {22'b0, ERROR_OVERFLOW});
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", {22'b0, data}, {22'b0, words[i]});
      read_strobe = 1'b1;
      tick();
    end
    read_strobe = 1'b0;
    check("ovf_drained", {31'b0, empty}, 32'd1);

    // full with simultaneous read and write
    do_reset();
    start_frame();
    for (int i = 0; i < 5; i++) words[i] = 10'($urandom);
    for (int i = 0; i < 4; i++) put(words[i]);
    read_strobe = 1'b1;
    put(words[4]);
    read_strobe = 1'b0;
    check("fr_error", {31'b0, error}, 32'd0);
    check("fr_full", {31'b0, full}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      check("fr_order", {22'b0, data}, {22'b0, words[i]});
      read_strobe = 1'b1;
      tick();
    end
    read_strobe = 1'b0;

    // rx_error capture and recovery
    do_reset();
    start_frame();
    rx_error = 1'b1;
    rx_data = ERROR_PARITY;
    tick();
    rx_error = 1'b0;
    check("rxe_error", {31'b0, error}, 32'd1);
    check("rxe_code", {22'b0, error_code}, {22'b0, ERROR_PARITY});
    put(10'h155);
    check("rxe_no_write", {31'b0, empty}, 32'd1);
    rx_active = 1'b0;
    tick();
    tick();
    do_reset();
    check("rxe_reset_error", {31'b0, error}, 32'd0);
    start_frame();
    rx_active = 1'b0;
    tick();
    check("rxe_idle_frame", {31'b0, frame_done}, 32'd1);

    // wrap-around
    do_reset();
    start_frame();
    for (int i = 0; i < 10; i++) begin
      words[i] = 10'($urandom);
      put(words[i]);
      check("wrap_order", {22'b0, data}, {22'b0, words[i]});
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
      check("wrap_not_full", {31'b0, full}, 32'd0);
    end

`ifdef COAX_RX_BUFFER_WORD_COUNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(10'(i + 5));
      check("cnt_up", 32'(count), 32'(i + 1));
    end
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    check("cnt_down", 32'(count), 32'd2);
`endif

    // reset mid-frame must not resume the frame
    do_reset();
    start_frame();
    put(10'h2a5);
    reset = 1'b1;
    #2;
    mq.delete();
    m_err = 1'b0;
    m_code = '0;
    m_recv = 1'b0;
    m_prev = 1'b1;
    m_fd = 1'b0;
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    rx_active = 1'b0;
    tick();
    check("mid_reset_no_done", {31'b0, frame_done}, 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        do_reset();
      end
      if ($urandom_range(0, 7) == 0) rx_active = ~rx_active;
      rx_strobe = ($urandom_range(0, 2) == 0);
      rx_error = ($urandom_range(0, 99) == 0);
      read_strobe = ($urandom_range(0, 2) == 0);
      rx_data = 10'($urandom);
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
